// File: rtl/and16_1.sv
// Word-by-bit AND gate: masks a WIDTH-bit word with a single enable bit.
// Combinational result and zero flag, plus a registered copy for pipelined users.
module and16_1 #(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic             B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             zero
);

  // Plain bitwise AND keeps bits with A[i]=0 at 0 even when B is unknown.
  always_comb begin
    Y    = A & {WIDTH{B}};
    zero = ~|Y;
  end

  // Registered copy; async clear wins over any coincident clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q <= RST_VAL;
    end else begin
      Y_q <= Y;
    end
  end

endmodule

// File: tb/tb_and16_1.sv
// Directed bench for and16_1: literal checks plus a per-cycle compare against
// a behavioural model of the gate and its one-cycle registered copy.
module tb_and16_1;

  localparam int unsigned      W   = 16;
  localparam logic [W-1:0]     RST = 16'h0000;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic         b;
  logic [W-1:0] y;
  logic [W-1:0] y_q;
  logic         zero;

  int checks   = 0;
  int failures = 0;

  logic         cmp_en = 1'b0;
  logic [W-1:0] exp_q  = RST;

  and16_1 #(.WIDTH(W), .RST_VAL(RST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a),
    .B    (b),
    .Y    (y),
    .Y_q  (y_q),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_y(input logic [W-1:0] av, input logic bv);
    return bv ? av : '0;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_in(input logic [W-1:0] av, input logic bv);
    a = av;
    b = bv;
    #1;
  endtask

  // Advance one clock; the model captures the gate output present before the edge.
  task automatic tick();
    logic [W-1:0] nxt;
    nxt = rst_n ? model_y(a, b) : RST;
    @(posedge clk);
    #1;
    exp_q = nxt;
  endtask

  // Continuous comparison on the inactive edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_y", y, model_y(a, b));
      check("cmp_zero", W'(zero), W'(model_y(a, b) == '0));
      check("cmp_q", y_q, exp_q);
    end
  end

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = 1'b0;
    #2;
    check("reset_q", y_q, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    cmp_en = 1'b1;

    // 1: all zero
    set_in(16'h0000, 1'b0);
    check("t1_y", y, 16'h0000);
    check("t1_zero", W'(zero), 16'h0001);
    tick();

    // 2: gate closed masks a nonzero word
    set_in(16'h5678, 1'b0);
    check("t2_y", y, 16'h0000);
    check("t2_zero", W'(zero), 16'h0001);
    tick();

    // 3: gate open passes the word, registered one edge later
    set_in(16'h5678, 1'b1);
    check("t3_y", y, 16'h5678);
    check("t3_zero", W'(zero), 16'h0000);
    check("t3_q_before", y_q, 16'h0000);
    tick();
    check("t3_q_after", y_q, 16'h5678);

    // 4: combinational response with no clock edge between changes
    set_in(16'hFFFF, 1'b1);
    check("t4_y_open", y, 16'hFFFF);
    set_in(16'hFFFF, 1'b0);
    check("t4_y_closed", y, 16'h0000);
    check("t4_zero", W'(zero), 16'h0001);
    check("t4_q_held", y_q, 16'h5678);
    tick();

    // 5: async reset mid-cycle clears Y_q only
    set_in(16'h5678, 1'b1);
    tick();
    check("t5_q_loaded", y_q, 16'h5678);
    rst_n = 1'b0;
    exp_q = RST;
    #1;
    check("t5_q_cleared", y_q, 16'h0000);
    check("t5_y_live", y, 16'h5678);
    check("t5_zero_live", W'(zero), 16'h0000);
    rst_n = 1'b1;
    #1;
    check("t5_q_wait", y_q, 16'h0000);
    tick();
    check("t5_q_reload", y_q, 16'h5678);

    // clock edge while reset held must not load Y_q
    set_in(16'hA5A5, 1'b1);
    rst_n = 1'b0;
    exp_q = RST;
    tick();
    check("hold_q", y_q, 16'h0000);
    check("hold_y", y, 16'hA5A5);
    rst_n = 1'b1;
    tick();
    check("hold_release", y_q, 16'hA5A5);

    // 6: walking one with B toggling
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] w;
      logic         bv;
      w  = W'(1) << i;
      bv = i[0];
      set_in(w, bv);
      check("t6_y", y, bv ? w : 16'h0000);
      tick();
    end
    check("t6_q_last", y_q, 16'h8000);

    // unknown B must not disturb bits where A is 0
    cmp_en = 1'b0;
    set_in(16'h00F0, 1'bx);
    check("x_masked", y & ~16'h00F0, 16'h0000);
    set_in(16'h0000, 1'b0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
